elastic_pipe_reg: RTL and testbench
===================================

Name: elastic_pipe_reg

Overview:
- Parametrised successor to the single-bit FF register: a DEPTH-stage, WIDTH-bit pipeline register with valid/ready handshake on both sides.
- Bubbles collapse, and a synchronous flush clears all stages.
- Sits between producer/consumer blocks in generated designs wherever a registered, stallable delay line is needed.
- Carries optional inline SVA, in the same style as the assertions our generator emits into module bodies.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1); unstalled latency in cycles.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- ASYNCRESETN  input  1  asynchronous active-low reset.
- I  input  WIDTH  input data.
- I_VALID  input  1  input data valid.
- I_READY  output  1  pipeline can accept I this cycle.
- O  output  WIDTH  output data (stage DEPTH-1 register).
- O_VALID  output  1  output data valid.
- O_READY  input  1  consumer accepts O this cycle.
- FLUSH  input  1  synchronous clear of all stage valids.
- COUNT  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset (ASYNCRESETN=0, takes effect immediately without a clock edge): all stage valid bits 0, all stage data 0, O=0, O_VALID=0, COUNT=0. I_READY=1 once reset deasserts and FLUSH=0.
- Stage k (0 = input side, DEPTH-1 = output side) holds data d[k] and valid v[k]. O=d[DEPTH-1], O_VALID=v[DEPTH-1].
- Advance condition, combinational from the output backwards:
  - adv[DEPTH] = O_READY.
  - adv[k] = !v[k] | adv[k+1].
  - I_READY = adv[0] & !FLUSH.
- Stage update on posedge when adv[k] is 1:
  - k=0: v[0] <= I_VALID & I_READY; d[0] <= I when I_VALID & I_READY, otherwise hold.
  - k>0: v[k] <= v[k-1]; d[k] <= d[k-1] when v[k-1], otherwise hold.
  - Data of an invalid stage is don't-care but must not toggle without a valid load.
- When adv[k] is 0 the stage holds both data and valid.
- Latency: with O_READY held 1, I sampled at edge t appears on O with O_VALID=1 after edge t+DEPTH-1, i.e. DEPTH cycles after presentation. Sustained throughput is 1 word/cycle.
- Bubble collapse: with O_READY=0, a new word still advances into empty downstream stages. The pipeline holds DEPTH words when full; I_READY=0 only when all v=1 and O_READY=0.
- Full with O_READY=1: simultaneous accept and emit is allowed. I_READY=1 and COUNT is unchanged.
- FLUSH=1: on the next edge all v <= 0 and data is held. I_READY=0 during FLUSH, so a concurrent I_VALID is dropped and is not a handshake. O_VALID remains as-is in the FLUSH cycle, so an O handshake in that cycle completes normally.
- COUNT: registered.
  - Next value is COUNT + (I_VALID&I_READY) - (O_VALID&O_READY), or 0 on FLUSH.
  - Invariant: COUNT equals the popcount of v and never exceeds DEPTH.
- Reset asserted mid-transfer: all in-flight words are discarded immediately. There is no partial output.

Optional Feature:
- Macro ELASTIC_PIPE_REG_SVA_EN.
- Defined: inline concurrent assertions clocked on posedge CLK, disabled iff !ASYNCRESETN:
  - O_VALID & !O_READY & !FLUSH |=> O_VALID & $stable(O)
  - COUNT <= DEPTH
  - COUNT == popcount(v)
  - I_VALID & I_READY & O_READY(held) |-> ##DEPTH O_VALID
  - cover property COUNT==DEPTH.
- Undefined: no assertion or cover code is elaborated, and functional RTL is identical.

Decomposition:
- Package elastic_pipe_reg_pkg contains:
  - function count_w(depth) returning $clog2(depth+1).
  - localparam MIN_DEPTH=1.
  - typedef for the stage state struct {valid, data} (WIDTH passed via the parameterised typedef in the module).
- Sub-module elastic_pipe_stage:
  - Owns one data/valid register pair with async active-low reset.
  - Inputs: in_data, in_valid, adv, flush.
  - Outputs: data, valid.
- The top module instantiates DEPTH of them in a generate loop and computes the adv chain, I_READY and COUNT.

Test Plan:
- Reset then stream: WIDTH=8, DEPTH=3, O_READY=1, I=0x01..0x05 on consecutive cycles -> O=0x01 with O_VALID first high 3 cycles after first accept, then 0x02..0x05 back-to-back; COUNT settles at 3.
- Backpressure fill: O_READY=0, push 0xA0,0xA1,0xA2 -> I_READY drops to 0 after the 3rd accept, COUNT=3, O holds 0xA0; raise O_READY -> 0xA0,0xA1,0xA2 drained in order, COUNT returns to 0.
- Full with simultaneous accept and emit: full pipe, O_READY=1, I_VALID=1 with I=0x55 -> I_READY=1, COUNT stays 3, 0x55 emerges 3 cycles later.
- Bubble collapse: DEPTH=4, push one word 0x77 with O_READY=0 -> word reaches stage 3 in 4 cycles; pipeline then accepts 3 more words before I_READY=0.
- Flush with concurrent input: 2 words in flight, FLUSH=1 with I_VALID=1 and I=0x99 -> I_READY=0, next cycle O_VALID=0 and COUNT=0, and 0x99 never appears on O.
- Async reset mid-stream: assert ASYNCRESETN=0 between clock edges while full -> O_VALID, O and COUNT go to 0 immediately; after release, new traffic flows with latency 3.

Source files
------------

// File: rtl/elastic_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_pipe_reg_pkg
//  Description : Shared constants and helpers for the elastic pipeline
//                register and its stage sub-module.
//                  MIN_DEPTH : smallest legal stage count.
//                  count_w() : width of an occupancy counter that must be
//                              able to hold the values 0..depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package elastic_pipe_reg_pkg;

    localparam int MIN_DEPTH = 1;

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/elastic_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_pipe_stage
//  Description : One data/valid register pair of the elastic pipeline.
//                Loads in_valid when the stage advances, loads in_data only
//                together with a valid word, and clears its valid bit on a
//                synchronous flush while holding its data.
//  Ports       : clk      - clock, rising edge
//                rst_n    - asynchronous active-low reset
//                in_data  - data offered by the upstream stage / input
//                in_valid - valid offered by the upstream stage / input
//                adv      - this stage may take a new value this cycle
//                flush    - synchronous clear of the valid bit
//                data     - registered stage data
//                valid    - registered stage valid
//  Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             adv,
    input  logic             flush,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    logic             r_valid_q;
    logic             w_valid_d;
    logic [WIDTH-1:0] r_data_q;
    logic [WIDTH-1:0] w_data_d;

    always_comb begin
        w_valid_d = r_valid_q;
        w_data_d  = r_data_q;
        if (flush) begin
            w_valid_d = 1'b0;
        end else if (adv) begin
            w_valid_d = in_valid;
            // Data only moves with a valid word so an empty stage never toggles.
            if (in_valid) begin
                w_data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_data_q  <= w_data_d;
        end
    end

    assign data  = r_data_q;
    assign valid = r_valid_q;

endmodule
`default_nettype wire

// File: rtl/elastic_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_pipe_reg
//  Description : DEPTH-stage, WIDTH-bit stallable pipeline register with
//                valid/ready handshakes on both sides. Empty stages are
//                filled even while the output is stalled (bubble collapse),
//                FLUSH synchronously empties every stage, and COUNT tracks
//                the number of occupied stages.
//  Ports       : CLK         - clock, rising edge
//                ASYNCRESETN - asynchronous active-low reset
//                I, I_VALID  - input word and its valid
//                I_READY     - input word is accepted this cycle
//                O, O_VALID  - output word (last stage) and its valid
//                O_READY     - consumer takes O this cycle
//                FLUSH       - synchronous clear of all stage valids
//                COUNT       - number of valid stages (registered)
//  Options     : `define ELASTIC_PIPE_REG_SVA_EN elaborates inline
//                assertions and a full-pipeline cover point.
//  Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipe_reg
    import elastic_pipe_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                      CLK,
    input  logic                      ASYNCRESETN,
    input  logic [WIDTH-1:0]          I,
    input  logic                      I_VALID,
    output logic                      I_READY,
    output logic [WIDTH-1:0]          O,
    output logic                      O_VALID,
    input  logic                      O_READY,
    input  logic                      FLUSH,
    output logic [count_w(DEPTH)-1:0] COUNT
);

    localparam int c_STAGES = (DEPTH < MIN_DEPTH) ? MIN_DEPTH : DEPTH;
    localparam int c_CW     = count_w(DEPTH);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t [c_STAGES-1:0] w_stage_in;
    logic   [c_STAGES:0]   w_adv;
    logic   [c_STAGES-1:0] w_valid;
    logic   [WIDTH-1:0]    w_data [c_STAGES];
    logic                  w_accept;
    logic                  w_emit;
    logic   [c_CW-1:0]     r_count_q;
    logic   [c_CW-1:0]     w_count_d;

    // A stage can advance if it is empty or the stage after it advances;
    // the chain therefore resolves from the consumer backwards.
    assign w_adv[c_STAGES] = O_READY;

    for (genvar k = 0; k < c_STAGES; k++) begin : g_stage
        assign w_adv[k] = ~w_valid[k] | w_adv[k+1];

        if (k == 0) begin : g_head
            assign w_stage_in[k] = '{valid: w_accept, data: I};
        end else begin : g_body
            assign w_stage_in[k] = '{valid: w_valid[k-1], data: w_data[k-1]};
        end

        elastic_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (CLK),
            .rst_n    (ASYNCRESETN),
            .in_data  (w_stage_in[k].data),
            .in_valid (w_stage_in[k].valid),
            .adv      (w_adv[k]),
            .flush    (FLUSH),
            .data     (w_data[k]),
            .valid    (w_valid[k])
        );
    end

    assign I_READY  = w_adv[0] & ~FLUSH;
    assign w_accept = I_VALID & I_READY;
    assign O        = w_data[c_STAGES-1];
    assign O_VALID  = w_valid[c_STAGES-1];
    // The output handshake still completes in a flush cycle.
    assign w_emit   = O_VALID & O_READY;

    always_comb begin
        w_count_d = r_count_q;
        if (FLUSH) begin
            w_count_d = '0;
        end else begin
            w_count_d = r_count_q + c_CW'(w_accept) - c_CW'(w_emit);
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign COUNT = r_count_q;

`ifdef ELASTIC_PIPE_REG_SVA_EN
    a_out_hold: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        (O_VALID && !O_READY && !FLUSH) |=> (O_VALID && $stable(O)));

    a_count_max: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        COUNT <= c_CW'(DEPTH));

    a_count_pop: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        COUNT == c_CW'($countones(w_valid)));

    a_latency: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        (I_VALID && I_READY) ##0 (O_READY && !FLUSH)[*DEPTH] |=> O_VALID);

    cv_full: cover property (@(posedge CLK) disable iff (!ASYNCRESETN)
        COUNT == c_CW'(DEPTH));
`endif

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elastic_pipe_reg
//  Description : Scoreboard bench for elastic_pipe_reg. Two instances:
//                DEPTH=3 (A) and DEPTH=4 (B), both WIDTH=8. A valid-bit
//                reference model predicts O_VALID, I_READY and COUNT; each
//                accepted word is queued and compared when it leaves.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_pipe_reg;

    localparam int c_DA = 3;
    localparam int c_DB = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] a_i = '0;
    logic       a_iv = 1'b0, a_ordy = 1'b0, a_fl = 1'b0;
    logic       a_ir, a_ov;
    logic [7:0] a_o;
    logic [1:0] a_cnt;

    logic [7:0] b_i = '0;
    logic       b_iv = 1'b0, b_ordy = 1'b0, b_fl = 1'b0;
    logic       b_ir, b_ov;
    logic [7:0] b_o;
    logic [2:0] b_cnt;

    int         n_checks = 0;
    int         n_pass   = 0;

    logic [3:0] mva = '0;
    logic [3:0] mvb = '0;
    logic       acc_a, acc_b;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    elastic_pipe_reg #(.WIDTH(8), .DEPTH(c_DA)) u_dut_a (
        .CLK(clk), .ASYNCRESETN(rst_n), .I(a_i), .I_VALID(a_iv), .I_READY(a_ir),
        .O(a_o), .O_VALID(a_ov), .O_READY(a_ordy), .FLUSH(a_fl), .COUNT(a_cnt)
    );

    elastic_pipe_reg #(.WIDTH(8), .DEPTH(c_DB)) u_dut_b (
        .CLK(clk), .ASYNCRESETN(rst_n), .I(b_i), .I_VALID(b_iv), .I_READY(b_ir),
        .O(b_o), .O_VALID(b_ov), .O_READY(b_ordy), .FLUSH(b_fl), .COUNT(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: the pipeline is full only when every stage holds a word.
    function automatic logic exp_rdy(input logic [3:0] v, input int d,
                                     input logic ordy, input logic fl);
        return !fl && (($countones(v) < d) || ordy);
    endfunction

    // Reference next valid bits: a word moves forward whenever the slot
    // ahead is free or being vacated in the same cycle.
    function automatic logic [3:0] step_v(input logic [3:0] v, input int d,
                                          input logic ordy, input logic acc,
                                          input logic fl);
        logic [3:0] n;
        logic       a;
        logic       adv_k;
        n = v;
        a = ordy;
        if (fl) return 4'b0;
        for (int k = d - 1; k >= 0; k--) begin
            adv_k = !v[k] || a;
            if (adv_k) begin
                if (k == 0) n[k] = acc;
                else        n[k] = v[k-1];
            end
            a = adv_k;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mva = '0;
            mvb = '0;
            qa.delete();
            qb.delete();
        end else begin
            acc_a = a_iv && exp_rdy(mva, c_DA, a_ordy, a_fl);
            if (acc_a) qa.push_back(a_i);
            if (a_fl) qa.delete();
            mva = step_v(mva, c_DA, a_ordy, acc_a, a_fl);
            acc_b = b_iv && exp_rdy(mvb, c_DB, b_ordy, b_fl);
            if (acc_b) qb.push_back(b_i);
            if (b_fl) qb.delete();
            mvb = step_v(mvb, c_DB, b_ordy, acc_b, b_fl);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_count",   32'(a_cnt), 32'($countones(mva)));
            chk("a_o_valid", 32'(a_ov),  32'(mva[c_DA-1]));
            chk("a_i_ready", 32'(a_ir),  32'(exp_rdy(mva, c_DA, a_ordy, a_fl)));
            if (mva[c_DA-1]) begin
                chk("a_sb_nonempty", 32'(qa.size() != 0), 32'd1);
                if (qa.size() != 0) begin
                    chk("a_data", 32'(a_o), 32'(qa[0]));
                    if (a_ordy) void'(qa.pop_front());
                end
            end
            chk("b_count",   32'(b_cnt), 32'($countones(mvb)));
            chk("b_o_valid", 32'(b_ov),  32'(mvb[c_DB-1]));
            chk("b_i_ready", 32'(b_ir),  32'(exp_rdy(mvb, c_DB, b_ordy, b_fl)));
            if (mvb[c_DB-1]) begin
                chk("b_sb_nonempty", 32'(qb.size() != 0), 32'd1);
                if (qb.size() != 0) begin
                    chk("b_data", 32'(b_o), 32'(qb[0]));
                    if (b_ordy) void'(qb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a(input int n);
        a_iv = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int  lat;
        bit  seen;
        int  nacc;

        // Reset state
        #12;
        chk("rst_o",       32'(a_o),   32'd0);
        chk("rst_o_valid", 32'(a_ov),  32'd0);
        chk("rst_count",   32'(a_cnt), 32'd0);
        chk("rst_b_valid", 32'(b_ov),  32'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("post_rst_i_ready", 32'(a_ir), 32'd1);

        // Stream 0x01..0x05 with the consumer always ready
        a_ordy = 1'b1;
        lat = 0;
        seen = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            a_iv = 1'b1;
            a_i  = 8'(i);
            tick();
            if (!seen) lat++;
            if (a_ov) seen = 1'b1;
        end
        a_iv = 1'b0;
        while (!seen && lat < 12) begin
            tick();
            lat++;
            if (a_ov) seen = 1'b1;
        end
        chk("stream_latency", 32'(lat), 32'd3);
        idle_a(5);

        // Backpressure fill, one refused word, then drain
        a_ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_iv = 1'b1;
            a_i  = 8'hA0 + 8'(i);
            tick();
        end
        a_i = 8'hA3;
        tick();
        tick();
        chk("bp_full_count", 32'(a_cnt), 32'd3);
        chk("bp_head",       32'(a_o),   32'hA0);
        a_iv   = 1'b0;
        a_ordy = 1'b1;
        idle_a(5);
        chk("bp_drained", 32'(a_cnt), 32'd0);

        // Full pipe: accept and emit in the same cycle
        a_ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_iv = 1'b1;
            a_i  = 8'hB0 + 8'(i);
            tick();
        end
        a_ordy = 1'b1;
        a_i    = 8'h55;
        #1;
        chk("full_accept_ready", 32'(a_ir), 32'd1);
        tick();
        chk("full_accept_count", 32'(a_cnt), 32'd3);
        idle_a(6);

        // Flush with two words in flight and a concurrent input
        a_ordy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_iv = 1'b1;
            a_i  = 8'hC0 + 8'(i);
            tick();
        end
        a_fl = 1'b1;
        a_i  = 8'h99;
        #1;
        chk("flush_i_ready", 32'(a_ir), 32'd0);
        tick();
        a_fl = 1'b0;
        a_iv = 1'b0;
        chk("flush_count",   32'(a_cnt), 32'd0);
        chk("flush_o_valid", 32'(a_ov),  32'd0);
        a_ordy = 1'b1;
        idle_a(5);

        // Flush while the output handshake completes in the same cycle
        for (int i = 0; i < 3; i++) begin
            a_iv = 1'b1;
            a_i  = 8'hD0 + 8'(i);
            tick();
        end
        a_fl = 1'b1;
        a_i  = 8'h99;
        tick();
        a_fl = 1'b0;
        a_iv = 1'b0;
        chk("flush_emit_count", 32'(a_cnt), 32'd0);
        idle_a(5);

        // Bubble collapse on the DEPTH=4 instance
        b_iv   = 1'b1;
        b_i    = 8'h77;
        tick();
        b_iv = 1'b0;
        tick();
        tick();
        tick();
        chk("bubble_head_valid", 32'(b_ov), 32'd1);
        chk("bubble_head_data",  32'(b_o),  32'h77);
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            b_iv = 1'b1;
            b_i  = 8'h78 + 8'(i);
            @(negedge clk);
            if (b_ir) nacc++;
            tick();
        end
        b_iv = 1'b0;
        chk("bubble_accepts", 32'(nacc),  32'd3);
        chk("bubble_count",   32'(b_cnt), 32'd4);
        b_ordy = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Asynchronous reset between edges while full
        a_ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_iv = 1'b1;
            a_i  = 8'hE0 + 8'(i);
            tick();
        end
        a_iv = 1'b0;
        chk("pre_rst_count", 32'(a_cnt), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_o_valid", 32'(a_ov),  32'd0);
        chk("async_rst_o",       32'(a_o),   32'd0);
        chk("async_rst_count",   32'(a_cnt), 32'd0);
        tick();
        rst_n  = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        a_ordy = 1'b1;
        a_iv   = 1'b1;
        a_i    = 8'h3C;
        tick();
        a_iv = 1'b0;
        lat  = 1;
        while (!a_ov && lat < 12) begin
            tick();
            lat++;
        end
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_data",    32'(a_o), 32'h3C);
        idle_a(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
